// File: rtl/gram_mask_pkg.sv
// gram_mask_pkg: shared definitions for the Gram/mask/weight engine.
//   - state_e    : engine FSM states
//   - h_width    : width of one Gram entry H[i][j] = 2*DW + clog2(L)
//   - sum_width  : width of a Gram row sum = h_width + clog2(N)
//   - is_pow2    : elaboration check helper for N
//   - tri_idx    : flat index of upper-triangle entry (k, j) with k <= j
package gram_mask_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MEAN = 3'd2,
    ST_WGT  = 3'd3,
    ST_OUT  = 3'd4
  } state_e;

  function automatic int h_width(input int dw, input int l);
    return 2 * dw + $clog2(l);
  endfunction

  function automatic int sum_width(input int dw, input int l, input int n);
    return h_width(dw, l) + $clog2(n);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  // Column j of the upper triangle starts after the j*(j+1)/2 entries of columns 0..j-1.
  function automatic int tri_idx(input int k, input int j);
    return (j * (j + 1)) / 2 + k;
  endfunction

endpackage

// File: rtl/gram_mask_engine_if.sv
// gram_mask_engine_if: stream bus of the Gram/mask/weight engine.
//   i_valid/i_data/i_ready : X elements, row-major
//   w_valid/w_data/w_ready : weight vector, ascending index
//   o_valid/o_data/o_ready : result vector, ascending index
// slave modport is the engine side, master modport is the producer/consumer side.
interface gram_mask_engine_if #(
  parameter int DW = 8,
  parameter int OW = 32
);
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          i_ready;
  logic          w_valid;
  logic [DW-1:0] w_data;
  logic          w_ready;
  logic          o_valid;
  logic [OW-1:0] o_data;
  logic          o_ready;

  modport slave (
    input  i_valid, i_data, w_valid, w_data, o_ready,
    output i_ready, w_ready, o_valid, o_data
  );

  modport master (
    output i_valid, i_data, w_valid, w_data, o_ready,
    input  i_ready, w_ready, o_valid, o_data
  );
endinterface

// File: rtl/gram_mac_lane.sv
// gram_mac_lane: one multiplier plus one result accumulator.
//   a, b    : multiplier operands (HW x DW, unsigned)
//   prod_lo : low HW bits of a*b, used to update Gram entries while loading
//   acc_en  : add the full product into y (weight phase)
//   clr     : end-of-frame clear of y
//   y       : full-precision accumulated result y_i
module gram_mac_lane #(
  parameter int DW = 8,
  parameter int HW = 20,
  parameter int YW = 31
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          acc_en,
  input  logic [HW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [HW-1:0] prod_lo,
  output logic [YW-1:0] y
);
  localparam int PW = HW + DW;

  logic [PW-1:0] prod_s;
  logic [YW-1:0] y_r;

  assign prod_s  = PW'(a) * PW'(b);
  assign prod_lo = prod_s[HW-1:0];
  assign y       = y_r;

  // Result accumulator, cleared by reset or at end of frame.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      y_r <= '0;
    end else if (acc_en) begin
      y_r <= y_r + YW'(prod_s);
    end else begin
      y_r <= y_r;
    end
  end
endmodule

// File: rtl/gram_mask_engine.sv
// gram_mask_engine: streams an LxN matrix X, accumulates H = X^T X (upper
// triangle only), masks each row of H against its mean, multiplies by a
// streamed weight vector and emits the N results.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave side of gram_mask_engine_if (X in, w in, y out)
module gram_mask_engine
  import gram_mask_pkg::*;
#(
  parameter int DW      = 8,
  parameter int N       = 8,
  parameter int L       = 16,
  parameter int OW      = 32,
  parameter bit MASK_EN = 1'b1
) (
  input logic               clk,
  input logic               rst,
  gram_mask_engine_if.slave bus
);
  localparam int HW = h_width(DW, L);
  localparam int SW = sum_width(DW, L, N);
  localparam int YW = HW + DW + $clog2(N);
  localparam int CW = $clog2(N);
  localparam int RW = $clog2(L);
  localparam int TN = N * (N + 1) / 2;

  if (!is_pow2(N)) begin : g_n_check
    $error("gram_mask_engine: N must be a power of two");
  end

  state_e        state_r, state_s;
  logic [DW-1:0] row_buf_r [N];
  logic [HW-1:0] h_r [TN];
  logic [HW-1:0] mean_r [N];
  logic [CW-1:0] col_r, wcnt_r, oidx_r;
  logic [RW-1:0] row_r;

  logic          in_acc_s, w_acc_s, o_acc_s;
  logic          last_x_s, last_w_s, last_o_s, clr_s;
  logic          i_ready_s, w_ready_s, o_valid_s;
  logic [OW-1:0] o_data_s;
  logic [HW-1:0] h_full_s [N][N];
  logic [SW-1:0] row_sum_s [N];
  logic [HW-1:0] lane_a_s [N];
  logic [DW-1:0] lane_b_s [N];
  logic [HW-1:0] lane_p_s [N];
  logic [YW-1:0] lane_y_s [N];

  function automatic logic [HW-1:0] mask_h(input logic [HW-1:0] h, input logic [HW-1:0] m);
    if (!MASK_EN || (h >= m)) begin
      return h;
    end else begin
      return '0;
    end
  endfunction

  // Symmetric view of H built from the stored upper triangle.
  for (genvar gi = 0; gi < N; gi++) begin : g_hi
    for (genvar gj = 0; gj < N; gj++) begin : g_hj
      if (gi <= gj) begin : g_up
        assign h_full_s[gi][gj] = h_r[tri_idx(gi, gj)];
      end else begin : g_lo
        assign h_full_s[gi][gj] = h_r[tri_idx(gj, gi)];
      end
    end
  end

  assign in_acc_s = bus.i_valid & i_ready_s;
  assign w_acc_s  = bus.w_valid & w_ready_s;
  assign o_acc_s  = o_valid_s & bus.o_ready;
  assign last_x_s = (col_r == CW'(N - 1)) && (row_r == RW'(L - 1));
  assign last_w_s = (wcnt_r == CW'(N - 1));
  assign last_o_s = (oidx_r == CW'(N - 1));
  assign clr_s    = o_acc_s & last_o_s;

  // Row sums of H for the mean computation.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      row_sum_s[i] = '0;
      for (int j = 0; j < N; j++) begin
        row_sum_s[i] = row_sum_s[i] + SW'(h_full_s[i][j]);
      end
    end
  end

  // Lane operand select: masked H column times weight in WGT, X products otherwise.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      if (state_r == ST_WGT) begin
        lane_a_s[k] = mask_h(h_full_s[k][wcnt_r], mean_r[k]);
        lane_b_s[k] = bus.w_data;
      end else if (CW'(k) == col_r) begin
        // Diagonal term: the incoming element squared.
        lane_a_s[k] = HW'(bus.i_data);
        lane_b_s[k] = bus.i_data;
      end else begin
        lane_a_s[k] = HW'(row_buf_r[k]);
        lane_b_s[k] = bus.i_data;
      end
    end
  end

  for (genvar gk = 0; gk < N; gk++) begin : g_lane
    gram_mac_lane #(.DW(DW), .HW(HW), .YW(YW)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr_s),
      .acc_en  (w_acc_s),
      .a       (lane_a_s[gk]),
      .b       (lane_b_s[gk]),
      .prod_lo (lane_p_s[gk]),
      .y       (lane_y_s[gk])
    );
  end

  // Datapath: row buffer, Gram accumulation, means and phase counters.
  always_ff @(posedge clk) begin
    if (rst || clr_s) begin
      for (int k = 0; k < N; k++) begin
        row_buf_r[k] <= '0;
        mean_r[k]    <= '0;
      end
      for (int t = 0; t < TN; t++) begin
        h_r[t] <= '0;
      end
      col_r  <= '0;
      row_r  <= '0;
      wcnt_r <= '0;
      oidx_r <= '0;
    end else begin
      if (in_acc_s) begin
        row_buf_r[col_r] <= bus.i_data;
        // Only column col_r of the triangle (rows k <= col_r) changes.
        for (int j = 0; j < N; j++) begin
          for (int k = 0; k <= j; k++) begin
            if (CW'(j) == col_r) begin
              h_r[tri_idx(k, j)] <= h_r[tri_idx(k, j)] + lane_p_s[k];
            end
          end
        end
        if (col_r == CW'(N - 1)) begin
          col_r <= '0;
          row_r <= last_x_s ? '0 : row_r + RW'(1'b1);
        end else begin
          col_r <= col_r + CW'(1'b1);
        end
      end
      if (state_r == ST_MEAN) begin
        for (int i = 0; i < N; i++) begin
          mean_r[i] <= HW'(row_sum_s[i] >> CW);
        end
      end
      if (w_acc_s) begin
        wcnt_r <= last_w_s ? '0 : wcnt_r + CW'(1'b1);
      end
      if (o_acc_s) begin
        oidx_r <= last_o_s ? '0 : oidx_r + CW'(1'b1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: if (in_acc_s) state_s = ST_LOAD; else state_s = ST_IDLE;
      ST_LOAD: if (in_acc_s && last_x_s) state_s = ST_MEAN; else state_s = ST_LOAD;
      ST_MEAN: state_s = ST_WGT;
      ST_WGT:  if (w_acc_s && last_w_s) state_s = ST_OUT; else state_s = ST_WGT;
      ST_OUT:  if (clr_s) state_s = ST_IDLE; else state_s = ST_OUT;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM outputs; everything is held low while reset is asserted.
  always_comb begin
    i_ready_s = 1'b0;
    w_ready_s = 1'b0;
    o_valid_s = 1'b0;
    o_data_s  = '0;
    if (rst) begin
      i_ready_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_LOAD: i_ready_s = 1'b1;
        ST_WGT:           w_ready_s = 1'b1;
        ST_OUT: begin
          o_valid_s = 1'b1;
          o_data_s  = OW'(lane_y_s[oidx_r]);
        end
        default: o_data_s = '0;
      endcase
    end
  end

  assign bus.i_ready = i_ready_s;
  assign bus.w_ready = w_ready_s;
  assign bus.o_valid = o_valid_s;
  assign bus.o_data  = o_data_s;
endmodule
